// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for the 16-bit TSC-style CPU: sequences fetch/decode/
// execute/memory/writeback and drives the datapath control strobes per state.
module mc_control_fsm #(
  parameter int WORD_SIZE   = 16,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic                 i_mem_read,
  output logic                 d_mem_read,
  output logic                 d_mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic                 alu_src,
  output logic [3:0]           alu_op,
  output logic                 mem_to_reg,
  output logic                 wwd_en,
  output logic                 is_halted,
  output logic                 mem_error,
  output logic [CNT_W-1:0]     num_inst,
  output logic [2:0]           state
);

  // state | meaning
  // RST   | post-reset, go fetch
  // IF    | instruction fetch, wait for inputReady
  // ID    | decode; HLT and JMP/JAL resolve here
  // EX    | ALU, branches, JPR/JRL, WWD
  // MEM   | LWD read / SWD write handshake
  // WB    | register file write
  // HALT  | absorbing, only reset exits
  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_LHI = 4'd8;

  state_t                state_q, state_d;
  logic [WORD_SIZE-1:0]  ir_q, ir_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  retire;

  logic [3:0] opcode;
  logic [5:0] func;
  logic is_rtype, is_branch, is_lwd, is_swd, is_jmp, is_jal;
  logic is_imm_alu, is_r_alu, is_jpr, is_jrl, is_wwd, is_hlt;
  logic unused_ir_bits;

  assign opcode = ir_q[WORD_SIZE-1 -: 4];
  assign func   = ir_q[5:0];
  assign unused_ir_bits = ^ir_q[WORD_SIZE-5:6];

  assign is_rtype   = (opcode == OP_R);
  assign is_branch  = (opcode >= OP_BNE) && (opcode <= OP_BLZ);
  assign is_lwd     = (opcode == OP_LWD);
  assign is_swd     = (opcode == OP_SWD);
  assign is_jmp     = (opcode == OP_JMP);
  assign is_jal     = (opcode == OP_JAL);
  assign is_imm_alu = (opcode == OP_ADI) || (opcode == OP_ORI) || (opcode == OP_LHI);
  assign is_r_alu   = is_rtype && (func < 6'd8);
  assign is_jpr     = is_rtype && (func == FN_JPR);
  assign is_jrl     = is_rtype && (func == FN_JRL);
  assign is_wwd     = is_rtype && (func == FN_WWD);
  assign is_hlt     = is_rtype && (func == FN_HLT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RST;
      ir_q    <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    wait_d      = wait_q;
    err_d       = err_q;
    retire      = 1'b0;
    i_mem_read  = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    mem_to_reg  = 1'b0;
    wwd_en      = 1'b0;
    is_halted   = 1'b0;

    case (state_q)
      S_RST: state_d = S_IF;

      S_IF: begin
        i_mem_read = 1'b1;
        // A strobe in the same cycle the counter hits the limit still wins.
        if (inputReady) begin
          ir_write = 1'b1;
          ir_d     = instruction;
          state_d  = S_ID;
        end else if (wait_q == WAIT_MAX) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_ID: begin
        if (is_hlt) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else if (is_jmp || is_jal) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          if (is_jal) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
          end
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        if (is_r_alu)                                     alu_op = func[3:0];
        else if (is_branch)                               alu_op = ALU_SUB;
        else if (opcode == OP_ORI)                        alu_op = ALU_ORR;
        else if (opcode == OP_LHI)                        alu_op = ALU_LHI;
        alu_src = is_imm_alu || is_lwd || is_swd;

        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = 2'd1;
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (is_jpr || is_jrl) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
          if (is_jrl) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
          end
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          // Sequential PC advance happens exactly once, here.
          pc_write = 1'b1;
          pc_src   = 2'd0;
          if (is_wwd) begin
            wwd_en  = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
          end else if (is_lwd || is_swd) begin
            state_d = S_MEM;
          end else if (is_r_alu || is_imm_alu) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end
      end

      S_MEM: begin
        d_mem_read  = is_lwd;
        d_mem_write = is_swd;
        if (is_lwd ? inputReady : ackOutput) begin
          if (is_lwd) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end else if (wait_q == WAIT_MAX) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lwd;
        reg_dst    = is_rtype ? 2'd1 : 2'd0;
        retire     = 1'b1;
        state_d    = S_IF;
      end

      S_HALT: is_halted = 1'b1;

      default: state_d = S_RST;
    endcase

    if ((state_d == S_IF || state_d == S_MEM) && (state_d != state_q)) wait_d = '0;
  end

  assign mem_error = err_q;
  assign num_inst  = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction expected cycle traces
// are built from the instruction class and compared cycle by cycle.
module tb_mc_control_fsm;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instruction = '0;
  logic        inputReady = 1'b0;
  logic        ackOutput = 1'b0;
  logic        i_mem_read, d_mem_read, d_mem_write, ir_write, pc_write;
  logic [1:0]  pc_src, reg_dst;
  logic        reg_write, alu_src, mem_to_reg, wwd_en, is_halted, mem_error;
  logic [3:0]  alu_op;
  logic [3:0]  num_inst;
  logic [2:0]  state;

  mc_control_fsm #(.WORD_SIZE(16), .CNT_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction),
    .inputReady(inputReady), .ackOutput(ackOutput),
    .i_mem_read(i_mem_read), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .wwd_en(wwd_en), .is_halted(is_halted),
    .mem_error(mem_error), .num_inst(num_inst), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       i_rd, d_rd, d_wr, irw, pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rd;
    logic       as;
    logic [3:0] ao;
    logic       m2r, wwd, halt;
    logic [2:0] st;
  } ctrl_t;

  typedef struct {
    ctrl_t c;
    logic  ir;
    logic  ack;
  } step_t;

  step_t      plan[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] exp_num = '0;

  function automatic ctrl_t blank(input logic [2:0] st);
    ctrl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic ctrl_t actual();
    return {i_mem_read, d_mem_read, d_mem_write, ir_write, pc_write, pc_src,
            reg_write, reg_dst, alu_src, alu_op, mem_to_reg, wwd_en, is_halted, state};
  endfunction

  task automatic push(input ctrl_t c, input logic ir, input logic ack);
    step_t s;
    s.c = c; s.ir = ir; s.ack = ack;
    plan.push_back(s);
  endtask

  // Expected trace of one instruction; the strobe not being awaited is random noise.
  task automatic build_plan(input logic [15:0] ins, input int w_if, input int w_mem,
                            output int retires);
    ctrl_t c;
    int op, fn;
    bit rtype, ralu, ityp_alu;
    op = int'(ins[15:12]);
    fn = int'(ins[5:0]);
    rtype = (op == 15);
    ralu = rtype && fn < 8;
    ityp_alu = (op >= 4 && op <= 6);
    retires = 1;
    plan.delete();
    for (int i = 0; i <= w_if; i++) begin
      c = blank(3'd1); c.i_rd = 1'b1; c.irw = (i == w_if);
      push(c, i == w_if, 1'($urandom));
    end
    c = blank(3'd2);
    if (rtype && fn == 29) begin
      push(c, 1'($urandom), 1'($urandom));
      c = blank(3'd6); c.halt = 1'b1;
      push(c, 1'($urandom), 1'($urandom));
      return;
    end
    if (op == 9 || op == 10) begin
      c.pcw = 1'b1; c.pcs = 2'd2;
      if (op == 10) begin c.rw = 1'b1; c.rd = 2'd2; end
      push(c, 1'($urandom), 1'($urandom));
      return;
    end
    push(c, 1'($urandom), 1'($urandom));
    c = blank(3'd3);
    if (ralu)                c.ao = 4'(fn);
    else if (op <= 3)        c.ao = 4'd1;
    else if (op == 5)        c.ao = 4'd3;
    else if (op == 6)        c.ao = 4'd8;
    c.as = (op >= 4 && op <= 8);
    if (op <= 3) begin
      c.pcw = 1'b1; c.pcs = 2'd1;
      push(c, 1'($urandom), 1'($urandom));
      return;
    end
    if (rtype && (fn == 25 || fn == 26)) begin
      c.pcw = 1'b1; c.pcs = 2'd3;
      if (fn == 26) begin c.rw = 1'b1; c.rd = 2'd2; end
      push(c, 1'($urandom), 1'($urandom));
      return;
    end
    c.pcw = 1'b1;
    if (rtype && fn == 28) c.wwd = 1'b1;
    push(c, 1'($urandom), 1'($urandom));
    if (op == 7 || op == 8) begin
      for (int i = 0; i <= w_mem; i++) begin
        c = blank(3'd4); c.d_rd = (op == 7); c.d_wr = (op == 8);
        if (op == 7) push(c, i == w_mem, 1'($urandom));
        else         push(c, 1'($urandom), i == w_mem);
      end
      if (op == 8) return;
    end
    if (op == 7 || ralu || ityp_alu) begin
      c = blank(3'd5); c.rw = 1'b1; c.m2r = (op == 7); c.rd = rtype ? 2'd1 : 2'd0;
      push(c, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic run_instr(input logic [15:0] ins, input int w_if, input int w_mem,
                           input string name);
    int ret;
    ctrl_t act;
    build_plan(ins, w_if, w_mem, ret);
    foreach (plan[k]) begin
      @(negedge clk);
      inputReady  = plan[k].ir;
      ackOutput   = plan[k].ack;
      instruction = (plan[k].c.st == 3'd1) ? ins : 16'($urandom);
      #1;
      act = actual();
      n_checks++;
      if (act !== plan[k].c || mem_error !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ins=%h cyc %0d ctrl actual %h required %h mem_error %b",
                 name, ins, k, act, plan[k].c, mem_error);
      end
    end
    exp_num = exp_num + 4'(ret);
    @(posedge clk); #1;
    n_checks++;
    if (num_inst !== exp_num) begin
      n_fail++;
      $display("FAIL %s num_inst actual %0d required %0d", name, num_inst, exp_num);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      inputReady = 1'($urandom); ackOutput = 1'($urandom); instruction = 16'($urandom);
      #1;
      n_checks++;
      if (actual() !== blank(3'd0) || num_inst !== 4'd0 || mem_error !== 1'b0) begin
        n_fail++;
        $display("FAIL reset ctrl actual %h required %h num_inst %0d mem_error %b",
                 actual(), blank(3'd0), num_inst, mem_error);
      end
    end
    reset_n = 1'b1;
    inputReady = 1'b0; ackOutput = 1'b0;
    exp_num = '0;
  endtask

  task automatic test_reset();
    ctrl_t c;
    do_reset();
    @(negedge clk); #1;
    c = blank(3'd1); c.i_rd = 1'b1;
    n_checks++;
    if (actual() !== c) begin
      n_fail++;
      $display("FAIL reset_release ctrl actual %h required %h", actual(), c);
    end
    do_reset();
  endtask

  task automatic test_directed();
    run_instr(16'hF1C0, 3, 0, "add");
    run_instr(16'h7106, 0, 5, "lwd");
    run_instr(16'h8106, 1, 2, "swd");
    run_instr(16'hA010, 0, 0, "jal");
    run_instr(16'h9123, 2, 0, "jmp");
    run_instr(16'hF01C, 0, 0, "wwd");
    run_instr(16'hF01A, 0, 0, "jrl");
    run_instr(16'h1234, 0, 0, "beq");
    run_instr(16'hB000, 0, 0, "undef_op");
    run_instr(16'hF03F, 0, 0, "undef_fn");
  endtask

  task automatic test_random(input int n, input bit zero_wait, input string name);
    int ops[16] = '{0,1,2,3,4,5,6,7,8,9,10,11,14,15,15,15};
    int fns[14] = '{0,1,2,3,4,5,6,7,25,26,28,12,63,28};
    logic [15:0] ins;
    for (int i = 0; i < n; i++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'(ops[$urandom_range(15, 0)]);
      if (ins[15:12] == 4'hF) ins[5:0] = 6'(fns[$urandom_range(13, 0)]);
      if (zero_wait) run_instr(ins, 0, 0, name);
      else run_instr(ins, $urandom_range(TO, 0), $urandom_range(TO, 0), name);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] ins;
    do_reset();
    for (int i = 0; i <= TO; i++) begin
      @(negedge clk);
      inputReady = 1'b0; ackOutput = 1'($urandom);
      #1;
      n_checks++;
      if (state !== 3'd1 || mem_error !== 1'b0) begin
        n_fail++;
        $display("FAIL if_wait cyc %0d state actual %0d required 1 mem_error %b", i, state, mem_error);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (state !== 3'd6 || mem_error !== 1'b1 || is_halted !== 1'b1) begin
      n_fail++;
      $display("FAIL if_timeout state actual %0d required 6 mem_error actual %b required 1",
               state, mem_error);
    end
    do_reset();
    ins = 16'hF2C1;
    run_instr(ins, TO, 0, "if_edge");
    run_instr(16'h7055, 0, TO, "lwd_edge");
    run_instr(16'h8055, TO, TO, "swd_edge");
    // LWD whose data never arrives.
    @(negedge clk); inputReady = 1'b1; instruction = 16'h7055;
    @(negedge clk); inputReady = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= TO; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (state !== 3'd4 || d_mem_read !== 1'b1 || mem_error !== 1'b0) begin
        n_fail++;
        $display("FAIL mem_wait cyc %0d state actual %0d required 4 d_mem_read %b", i, state, d_mem_read);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (state !== 3'd6 || mem_error !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_timeout state actual %0d required 6 mem_error actual %b required 1",
               state, mem_error);
    end
    do_reset();
  endtask

  task automatic test_halt();
    ctrl_t c;
    run_instr(16'h4321, 0, 0, "pre_hlt");
    run_instr(16'hF01D, 1, 0, "hlt");
    c = blank(3'd6); c.halt = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      inputReady = 1'($urandom); ackOutput = 1'($urandom); instruction = 16'($urandom);
      #1;
      n_checks++;
      if (actual() !== c || num_inst !== exp_num) begin
        n_fail++;
        $display("FAIL halt_frozen cyc %0d ctrl actual %h required %h num_inst %0d/%0d",
                 i, actual(), c, num_inst, exp_num);
      end
    end
    do_reset();
    run_instr(16'hF1C0, 0, 0, "after_halt");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random(30, 1'b1, "back_to_back");
    test_random(40, 1'b0, "random");
    test_timeout();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
